// File: rtl/solitaire_pkg.sv
// Shared constants, FSM state type and board geometry for the solitaire board blocks.
package solitaire_pkg;

  localparam int BOARD_DIM = 7;
  localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM;
  localparam logic [7:0] FRAME_HDR_DEFAULT = 8'hA5;
  localparam int FRAME_LEN = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // A position is a playable hole if it lies in the central row band or column band.
  function automatic logic is_hole(input int x, input int y);
    return ((x >= 2) && (x <= 4)) || ((y >= 2) && (y <= 4));
  endfunction

endpackage

// File: rtl/solitaire_popcount.sv
// Combinational 49-bit population count, 6-bit result.
module solitaire_popcount (
  input  logic [48:0] bits,
  output logic [5:0]  count
);

  always_comb begin
    count = 6'd0;
    for (int i = 0; i < 49; i++) begin
      count = count + {5'd0, bits[i]};
    end
  end

endmodule

// File: rtl/solitaire_board_tx.sv
// Serialises a masked peg-board snapshot as a 10-byte frame over a valid/ready byte link.
// Byte index advances only on accept; one start may be queued during a frame for a gapless follow-on.
module solitaire_board_tx
  import solitaire_pkg::*;
#(
  parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEFAULT,
  parameter int BOARD_DIM = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [48:0] board_i,
  input  logic        start_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  tx_state_t   state;
  tx_state_t   state_next;
  logic [3:0]  idx;
  logic        pending;
  logic        done;
  logic [48:0] snap;
  logic [48:0] masked;
  logic [5:0]  peg_count;
  logic [6:0][6:0] rows;
  logic [7:0]  checksum;
  logic        accept;
  logic        last_accept;

  assign accept      = (state == SEND) && tx_ready_i;
  assign last_accept = accept && (idx == 4'(FRAME_LEN - 1));

  // Corner bits are forced to zero so they never reach rows, count or checksum.
  always_comb begin
    masked = '0;
    for (int y = 0; y < BOARD_DIM; y++) begin
      for (int x = 0; x < BOARD_DIM; x++) begin
        masked[y*BOARD_DIM+x] = board_i[y*BOARD_DIM+x] & is_hole(x, y);
      end
    end
  end

  solitaire_popcount u_popcount (
    .bits  (snap),
    .count (peg_count)
  );

  always_comb begin
    checksum = FRAME_HDR ^ {2'b00, peg_count};
    for (int y = 0; y < 7; y++) begin
      rows[y]  = snap[y*7 +: 7];
      checksum = checksum ^ {1'b0, snap[y*7 +: 7]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = SEND;
      SEND: if (last_accept && !(pending || start_i)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= 4'd0;
      pending <= 1'b0;
      done    <= 1'b0;
      snap    <= '0;
    end else begin
      done <= last_accept;
      if (state == IDLE) begin
        if (start_i) begin
          snap <= masked;
          idx  <= 4'd0;
        end
      end else begin
        if (accept) begin
          idx <= last_accept ? 4'd0 : idx + 4'd1;
        end
        // A start landing on the final accept is folded into the pending path.
        if (last_accept) begin
          if (pending || start_i) snap <= masked;
          pending <= 1'b0;
        end else if (start_i) begin
          pending <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_valid_o   = (state == SEND);
    busy_o       = (state == SEND) || pending;
    frame_done_o = done;
    tx_data_o    = 8'h00;
    if (state == SEND) begin
      if (idx == 4'd0)       tx_data_o = FRAME_HDR;
      else if (idx <= 4'd7)  tx_data_o = {1'b0, rows[3'(idx - 4'd1)]};
      else if (idx == 4'd8)  tx_data_o = {2'b00, peg_count};
      else                   tx_data_o = checksum;
    end
  end

endmodule

// File: tb/tb_solitaire_board_tx.sv
// Directed bench for solitaire_board_tx with a byte-queue reference model and literal frame checks.
module tb_solitaire_board_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [48:0] board_i = '0;
  logic        start_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic        busy_o;
  logic        frame_done_o;

  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [7:0] exp_q[$];
  bit         m_pend = 0;
  bit         m_done = 0;

  logic [7:0] got_q[$];
  logic [7:0] want_q[$];
  int         vld_cycles = 0;

  logic       prev_v = 0, prev_r = 0;
  logic [7:0] prev_d = 8'h00;

  logic [7:0] std_frame[10]  = '{8'hA5, 8'h1C, 8'h1C, 8'h7F, 8'h77, 8'h7F, 8'h1C, 8'h1C, 8'h20, 8'hF2};
  logic [7:0] ones_frame[10] = '{8'hA5, 8'h1C, 8'h1C, 8'h7F, 8'h7F, 8'h7F, 8'h1C, 8'h1C, 8'h21, 8'hFB};
  logic [7:0] zero_frame[10] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
  logic [48:0] std_board;

  always #5 clk = ~clk;

  solitaire_board_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .board_i      (board_i),
    .start_i      (start_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Frame contents derived directly from the board rules: header, rows, count, xor.
  task automatic build_frame(input logic [48:0] b);
    logic [48:0] m;
    logic [7:0]  bytes[10];
    int          cnt;
    logic [7:0]  x8;
    m = b;
    cnt = 0;
    for (int y = 0; y < 7; y++)
      for (int x = 0; x < 7; x++)
        if ((x < 2 || x > 4) && (y < 2 || y > 4)) m[y*7+x] = 1'b0;
    for (int i = 0; i < 49; i++) cnt += int'(m[i]);
    bytes[0] = 8'hA5;
    for (int y = 0; y < 7; y++) bytes[y+1] = {1'b0, m[y*7 +: 7]};
    bytes[8] = 8'(cnt);
    x8 = 8'h00;
    for (int i = 0; i < 9; i++) x8 ^= bytes[i];
    bytes[9] = x8;
    for (int i = 0; i < 10; i++) exp_q.push_back(bytes[i]);
  endtask

  always @(posedge clk) begin
    bit acc, lastacc;
    if (!rst_n) begin
      exp_q.delete();
      m_pend = 0;
      m_done = 0;
    end else begin
      acc     = (exp_q.size() > 0) && tx_ready_i;
      lastacc = acc && (exp_q.size() == 1);
      m_done  = lastacc;
      if (exp_q.size() == 0) begin
        if (start_i) build_frame(board_i);
      end else begin
        if (acc) void'(exp_q.pop_front());
        if (lastacc) begin
          if (m_pend || start_i) build_frame(board_i);
          m_pend = 0;
        end else if (start_i) begin
          m_pend = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model valid", {7'd0, tx_valid_o}, {7'd0, exp_q.size() > 0});
      chk("model busy", {7'd0, busy_o}, {7'd0, (exp_q.size() > 0) || m_pend});
      chk("model done", {7'd0, frame_done_o}, {7'd0, m_done});
      if (exp_q.size() > 0) chk("model data", tx_data_o, exp_q[0]);
      if (rst_n && prev_v && !prev_r) begin
        chk("stall valid hold", {7'd0, tx_valid_o}, 8'd1);
        chk("stall data hold", tx_data_o, prev_d);
      end
      if (tx_valid_o) vld_cycles++;
      if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
    end
    prev_v = tx_valid_o;
    prev_r = tx_ready_i;
    prev_d = tx_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done_o === 1'b1) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("frame_done within budget", {7'd0, seen}, 8'd1);
  endtask

  task automatic load_want(input logic [7:0] a[10]);
    for (int i = 0; i < 10; i++) want_q.push_back(a[i]);
  endtask

  task automatic chk_got(input string name);
    chk({name, " byte count"}, 8'(got_q.size()), 8'(want_q.size()));
    for (int i = 0; i < want_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s byte %0d", name, i), got_q[i], want_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int y = 0; y < 7; y++) std_board[y*7 +: 7] = std_frame[y+1][6:0];

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset valid", {7'd0, tx_valid_o}, 8'd0);
    chk("reset data", tx_data_o, 8'h00);
    chk("reset busy", {7'd0, busy_o}, 8'd0);
    chk("reset done", {7'd0, frame_done_o}, 8'd0);
    chk_en = 1;
    rst_n = 1'b1;
    tick();

    // Standard board, sink always ready.
    board_i = std_board;
    got_q.delete(); want_q.delete(); vld_cycles = 0;
    do_start();
    chk("first byte header", tx_data_o, 8'hA5);
    wait_done(50);
    tick();
    load_want(std_frame);
    chk_got("std frame");
    chk("std frame cycles", 8'(vld_cycles), 8'd10);

    // All ones: corners masked.
    board_i = '1;
    got_q.delete(); want_q.delete();
    do_start();
    wait_done(50);
    tick();
    load_want(ones_frame);
    chk_got("ones frame");

    // Sink ready alternating 0/1.
    board_i = std_board;
    got_q.delete(); want_q.delete(); vld_cycles = 0;
    tx_ready_i = 1'b0;
    do_start();
    for (int k = 0; k < 60; k++) begin
      tx_ready_i = k[0];
      tick();
      if (frame_done_o === 1'b1) break;
    end
    tx_ready_i = 1'b1;
    chk("toggle done seen", {7'd0, frame_done_o}, 8'd1);
    tick();
    load_want(std_frame);
    chk_got("toggle frame");
    chk("toggle frame cycles", 8'(vld_cycles), 8'd20);

    // Three starts during a frame: one queued, two frames back to back.
    board_i = std_board;
    got_q.delete(); want_q.delete(); vld_cycles = 0;
    do_start();
    for (int c = 0; c < 10; c++) begin
      start_i = (c == 2 || c == 5 || c == 9);
      if (c == 3) board_i = '0;
      tick();
    end
    start_i = 1'b0;
    chk("b2b done pulse", {7'd0, frame_done_o}, 8'd1);
    chk("b2b no gap valid", {7'd0, tx_valid_o}, 8'd1);
    chk("b2b second header", tx_data_o, 8'hA5);
    tick();
    wait_done(50);
    tick();
    load_want(std_frame);
    load_want(zero_frame);
    chk_got("b2b frames");
    chk("b2b cycles", 8'(vld_cycles), 8'd20);
    chk("b2b idle busy", {7'd0, busy_o}, 8'd0);

    // Reset while byte 4 is on the link.
    board_i = std_board;
    do_start();
    repeat (4) tick();
    chk("pre-reset byte4", tx_data_o, 8'h77);
    rst_n = 1'b0;
    tick();
    chk("abort valid", {7'd0, tx_valid_o}, 8'd0);
    chk("abort busy", {7'd0, busy_o}, 8'd0);
    chk("abort done", {7'd0, frame_done_o}, 8'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post-reset idle valid", {7'd0, tx_valid_o}, 8'd0);
      chk("post-reset no done", {7'd0, frame_done_o}, 8'd0);
    end
    got_q.delete(); want_q.delete();
    do_start();
    wait_done(50);
    tick();
    load_want(std_frame);
    chk_got("post-reset frame");

    // Irregular board, model-checked only.
    board_i = 49'h1_5555_AAAA_3C3C;
    do_start();
    wait_done(50);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/solitaire_board_tx.md
SOLITAIRE_BOARD_TX -- requirements
Module: solitaire_board_tx

Interface
REQ-001 Parameter: FRAME_HDR, default 8'hA5, first byte of every frame.
REQ-002 Parameter: BOARD_DIM, default 7, board side length; only 7 is supported.
REQ-003 Port: clk, input, 1, sole clock; all state on rising edge.
REQ-004 Port: rst_n, input, 1, reset; synchronous, active-low.
REQ-005 Port: board_i, input, 49, live peg map; bit index y*7+x, x,y in 0..6; 1 = peg.
REQ-006 Port: start_i, input, 1, single-cycle request to transmit one board frame.
REQ-007 Port: tx_data_o, output, 8, frame byte.
REQ-008 Port: tx_valid_o, output, 1, tx_data_o holds a valid byte.
REQ-009 Port: tx_ready_i, input, 1, sink accepts the byte when tx_valid_o and tx_ready_i are both 1.
REQ-010 Port: busy_o, output, 1, a frame is in progress or pending.
REQ-011 Port: frame_done_o, output, 1, one-cycle pulse in the cycle after the last byte is accepted.

Function
REQ-012 Frame SHALL be 10 bytes: FRAME_HDR; rows y=0..6 as {1'b0, row[6:0]} with bit x = peg at (x,y); peg count (0..33); XOR of bytes 0..8.
REQ-013 Board snapshot SHALL mask non-holes: bits with (x<2 or x>4) and (y<2 or y>4) forced 0 before row, count and checksum use.
REQ-014 FSM states SHALL be IDLE and SEND, with a 4-bit byte index 0..9.
REQ-015 start_i in IDLE at cycle N SHALL snapshot board_i at edge N; tx_valid_o=1 with FRAME_HDR in cycle N+1.
REQ-016 Byte index SHALL advance only on accept; tx_data_o and tx_valid_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0.
REQ-017 With tx_ready_i held 1, a frame SHALL occupy exactly 10 consecutive cycles.
REQ-018 tx_valid_o SHALL never drop in SEND until byte 9 is accepted.
REQ-019 Accept of byte 9 SHALL return to IDLE (tx_valid_o=0 next cycle) and pulse frame_done_o next cycle.
REQ-020 start_i during SEND SHALL set a single pending flag; further starts while pending SHALL be dropped.
REQ-021 If pending at byte-9 accept, FSM SHALL stay in SEND, take a fresh snapshot at that edge, clear pending, and present FRAME_HDR the next cycle with no gap; frame_done_o still pulses.
REQ-022 start_i coincident with byte-9 accept SHALL be treated as pending per REQ-021.
REQ-023 board_i changes during SEND SHALL not affect the current frame.
REQ-024 busy_o SHALL equal (state==SEND) or pending.
REQ-025 Peg count SHALL be the 6-bit popcount of the masked snapshot; checksum SHALL be computed combinationally from the snapshot.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, index 0, pending 0, tx_valid_o 0, tx_data_o 8'h00, busy_o 0, frame_done_o 0, snapshot 0.
REQ-027 Reset mid-frame SHALL abort without completing the frame or pulsing frame_done_o; first post-reset frame requires a new start_i.

Structure
REQ-028 solitaire_pkg SHALL hold BOARD_DIM, FRAME_HDR default, FRAME_LEN=10, the FSM state enum and an is_hole(x,y) function shared with the game core.
REQ-029 Popcount SHALL be one sub-module, solitaire_popcount (49-bit in, 6-bit out, combinational).

Verification
REQ-030 Standard start board (33 holes, centre empty), ready=1 -> bytes A5 1C 1C 7F 77 7F 1C 1C 20 F2, frame_done_o one cycle after F2.
REQ-031 board_i all ones -> corners masked: rows 1C 1C 7F 7F 7F 1C 1C, count 21 (33), checksum matches REQ-012.
REQ-032 tx_ready_i toggled 1/0 each cycle -> byte sequence identical to REQ-030; data stable in stall cycles; 20 cycles total.
REQ-033 start_i pulsed three times during a frame -> exactly two frames back-to-back, no idle cycle between; second uses board_i at byte-9 accept.
REQ-034 rst_n low at byte 4 -> tx_valid_o 0 next cycle, no frame_done_o, busy_o 0; new start_i yields a full frame from A5.
